// File: rtl/edge_result_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : edge_result_buffer_if
// Purpose  : Handshake and status bundle between the edge result buffer and
//            its producer/consumer environment.
// Revision : 1.0 - initial release
// ============================================================================
interface edge_result_buffer_if #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] threshold;
    logic              out_ready;
    logic              clear_stats;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_edge;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [CNT_W-1:0]  edge_count;

    // Environment side: drives the stream and control, observes results.
    modport master (
        output in_valid, in_data, threshold, out_ready, clear_stats,
        input  out_valid, out_data, out_edge, count, full, empty,
               overflow, edge_count
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_data, threshold, out_ready, clear_stats,
        output out_valid, out_data, out_edge, count, full, empty,
               overflow, edge_count
    );
endinterface
`default_nettype wire

// File: rtl/edge_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : edge_result_buffer
// Purpose  : Show-ahead FIFO for the multiply-stage product stream. Each
//            entry carries an edge flag (data >= threshold at write time).
//            Keeps a sticky drop flag and a saturating count of popped edges.
// Revision : 1.0 - initial release
// ============================================================================
module edge_result_buffer #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    edge_result_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0]    c_PTR_ONE  = AW'(1);
    localparam logic [CW-1:0]    c_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    c_CNT_FULL = CW'(DEPTH);
    localparam logic [CNT_W-1:0] c_EC_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_EC_MAX   = {CNT_W{1'b1}};

    // Entry layout: {edge_flag, data}
    logic [DATA_W:0]    r_mem [DEPTH];
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_edge_count;

    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_edge_in;
    logic               w_drop;
    logic [DATA_W:0]    w_head;

    // Status derives only from registered occupancy; the handshake inputs
    // never feed full/empty/count combinationally.
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_pop     = !w_empty && bus.out_ready;
    // A full buffer still accepts a write when the head leaves this cycle.
    assign w_push    = bus.in_valid && (!w_full || w_pop);
    assign w_drop    = bus.in_valid && w_full && !w_pop;
    assign w_edge_in = (bus.in_data >= bus.threshold);
    assign w_head    = r_mem[r_rd_ptr];

    // Storage write; contents are don't-care until pointed at by a valid entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_edge_in, bus.in_data};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    // Frame statistics; clear_stats wins over a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_edge_count <= '0;
        end else if (bus.clear_stats) begin
            r_overflow   <= 1'b0;
            r_edge_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop && w_head[DATA_W] && (r_edge_count != c_EC_MAX)) begin
                r_edge_count <= r_edge_count + c_EC_ONE;
            end
        end
    end

    // Show-ahead head presentation, forced to zero while empty.
    assign bus.out_valid  = !w_empty;
    assign bus.out_data   = w_empty ? '0   : w_head[DATA_W-1:0];
    assign bus.out_edge   = w_empty ? 1'b0 : w_head[DATA_W];
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.edge_count = r_edge_count;

endmodule
`default_nettype wire

// File: tb/tb_edge_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_result_buffer
// Purpose  : Directed and random stimulus against a queue-based model of the
//            edge result buffer; a narrow-counter instance shares the inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_result_buffer;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [DATA_W-1:0] threshold = '0;
    logic              out_ready = 1'b0;
    logic              clear_stats = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: queue of {edge, data}, unbounded edge tally.
    logic [DATA_W:0] q[$];
    int              ec  = 0;
    bit              ovf = 1'b0;

    always #5 clk = ~clk;

    edge_result_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus_a ();
    edge_result_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4))     bus_b ();

    assign bus_a.in_valid    = in_valid;
    assign bus_a.in_data     = in_data;
    assign bus_a.threshold   = threshold;
    assign bus_a.out_ready   = out_ready;
    assign bus_a.clear_stats = clear_stats;
    assign bus_b.in_valid    = in_valid;
    assign bus_b.in_data     = in_data;
    assign bus_b.threshold   = threshold;
    assign bus_b.out_ready   = out_ready;
    assign bus_b.clear_stats = clear_stats;

    edge_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    edge_result_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        check("out_valid",  32'(bus_a.out_valid), 32'(sz != 0));
        check("out_data",   32'(bus_a.out_data),  (sz != 0) ? 32'(q[0][DATA_W-1:0]) : 32'd0);
        check("out_edge",   32'(bus_a.out_edge),  (sz != 0) ? 32'(q[0][DATA_W]) : 32'd0);
        check("count",      32'(bus_a.count),     32'(sz));
        check("full",       32'(bus_a.full),      32'(sz == DEPTH));
        check("empty",      32'(bus_a.empty),     32'(sz == 0));
        check("overflow",   32'(bus_a.overflow),  32'(ovf));
        check("edge_count", 32'(bus_a.edge_count), (ec > 65535) ? 32'd65535 : 32'(ec));
        check("edge_cnt4",  32'(bus_b.edge_count), (ec > 15) ? 32'd15 : 32'(ec));
        check("data4",      32'(bus_b.out_data),  32'(bus_a.out_data));
    endtask

    // One clock of stimulus followed by a model update and full comparison.
    task automatic step(input bit iv, input int d, input int th, input bit rdy, input bit clr);
        bit is_full, pop, push, e;
        in_valid    = iv;
        in_data     = DATA_W'(d);
        threshold   = DATA_W'(th);
        out_ready   = rdy;
        clear_stats = clr;
        is_full = (q.size() == DEPTH);
        pop     = (q.size() != 0) && rdy;
        push    = iv && (!is_full || pop);
        e       = ((d % 512) >= (th % 512));
        @(posedge clk);
        if (pop) begin
            if (q[0][DATA_W]) ec++;
            void'(q.pop_front());
        end
        if (push) q.push_back({e, DATA_W'(d)});
        if (clr) begin
            ec  = 0;
            ovf = 1'b0;
        end else if (iv && is_full && !pop) begin
            ovf = 1'b1;
        end
        #1;
        check_all();
    endtask

    // Reset with busy inputs to show they are ignored.
    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = DATA_W'($urandom_range(0, 511));
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
        end
        #1;
        q.delete();
        ec  = 0;
        ovf = 1'b0;
        rst = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_all();
    endtask

    initial begin
        // Reset then idle
        do_reset(2);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);

        // Single push, one-cycle latency, pop with edge
        step(1, 120, 100, 0, 0);
        step(0, 0, 100, 0, 0);
        step(0, 0, 100, 1, 0);
        step(0, 0, 100, 0, 0);

        // Fill, overflow on ninth, drain in order
        for (int i = 0; i < 8; i++) step(1, i * 10, 50, 0, 0);
        step(1, 200, 50, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 50, 1, 0);
        step(0, 0, 50, 1, 0);

        // Full with simultaneous push/pop across pointer wrap
        for (int i = 0; i < 8; i++) step(1, i, 50, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 300 + i, 50, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 50, 1, 0);

        // Threshold sampled at write; equality counts as edge
        step(1, 80, 100, 0, 0);
        step(0, 0, 10, 0, 0);
        step(0, 0, 10, 1, 0);
        step(1, 100, 100, 0, 0);
        step(0, 0, 100, 1, 0);

        // Drive narrow counter through saturation
        for (int i = 0; i < 17; i++) step(1, 400, 10, 1, 0);
        step(0, 0, 10, 1, 0);

        // clear_stats concurrent with an edge pop (overflow still set here)
        step(1, 250, 10, 0, 0);
        step(0, 0, 10, 1, 1);

        // clear_stats concurrent with an overflow event
        for (int i = 0; i < 8; i++) step(1, 20 + i, 22, 0, 0);
        step(1, 5, 0, 0, 1);
        step(1, 6, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);

        // Reset with five entries buffered
        for (int i = 0; i < 5; i++) step(1, 60 + i, 0, 0, 0);
        do_reset(1);
        step(0, 0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, int'($urandom % 512), int'($urandom % 512),
                 ($urandom % 3) != 0, ($urandom % 50) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
